// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Two-digit, common-anode, active-low 7-segment driver.
// ASCII hex characters shift into a two-nibble buffer. The newest character
// becomes the low digit. The digit picked by sel is shown on seg/an. Every
// change of sel blanks both anodes for BLANK_CYCLES clocks to stop ghosting.
module seg7_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 1000  // legal range 1..65535
) (
  input  logic       clk,
  input  logic       rst,       // synchronous, active-low
  input  logic       sel,       // 0 = low digit, 1 = high digit
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] seg,       // {g,f,e,d,c,b,a}, active-low
  output logic [1:0] an,        // active-low; an[0] = low digit
  output logic       err
);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(BLANK_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [7:0]  disp_reg;
  logic        sel_q;
  logic        sel_edge;
  logic        is_hex;
  logic [3:0]  rx_nib;
  logic [6:0]  seg_next;
  logic [1:0]  an_next;
  logic        show_next;

  // Decode one nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'h0: dec7 = 7'h40;
      4'h1: dec7 = 7'h79;
      4'h2: dec7 = 7'h24;
      4'h3: dec7 = 7'h30;
      4'h4: dec7 = 7'h19;
      4'h5: dec7 = 7'h12;
      4'h6: dec7 = 7'h02;
      4'h7: dec7 = 7'h78;
      4'h8: dec7 = 7'h00;
      4'h9: dec7 = 7'h10;
      4'hA: dec7 = 7'h08;
      4'hB: dec7 = 7'h03;
      4'hC: dec7 = 7'h46;
      4'hD: dec7 = 7'h21;
      4'hE: dec7 = 7'h06;
      default: dec7 = 7'h0E;
    endcase
  endfunction

  // sel already comes from this clock domain, so a single delay stage detects its edges.
  assign sel_edge = sel ^ sel_q;

  // Map an ASCII character to a nibble. Upper-case and lower-case A-F both count as hex.
  always_comb begin
    is_hex = 1'b1;
    rx_nib = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      rx_nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      rx_nib = rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end

  // Buffer shift, sel delay, and a one-cycle error pulse for a rejected character.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_reg <= 8'h00;
      sel_q    <= 1'b0;
      err      <= 1'b0;
    end else begin
      sel_q <= sel;
      err   <= rx_valid && !is_hex;
      if (rx_valid && is_hex) begin
        disp_reg <= {disp_reg[3:0], rx_nib};
      end
    end
  end

  // FSM state register, together with its blank-time counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= BLANK;
      cnt_reg   <= 16'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state. A sel edge restarts the full blank time from any state.
  // cnt stops advancing on leaving BLANK, so it can never wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (sel_edge) begin
      state_next = BLANK;
      cnt_next   = 16'd0;
    end else if (state_reg == BLANK) begin
      cnt_next = cnt_reg + 16'd1;
      if (cnt_reg == CNT_LAST) begin
        state_next = SHOW;
      end
    end
  end

  // The outputs are computed from the next state, so the registered pins change
  // on the same edge as the state. Blank then lasts exactly BLANK_CYCLES clocks.
  assign show_next = (state_next == SHOW);

  always_comb begin
    seg_next = 7'h7F;
    if (show_next) begin
      seg_next = dec7(sel ? disp_reg[7:4] : disp_reg[3:0]);
    end
  end

  // One anode per digit. A digit's anode is low only while showing with sel pointing at it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_an
    assign an_next[gi] = ~(show_next && (sel == 1'(gi)));
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an  <= 2'b11;
      seg <= 7'h7F;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule
